// File: rtl/vx_cache_cfg_ctrl.sv
// vx_cache_cfg_ctrl: sequences a runtime change of the cache cluster's set
// count. A request is validated, core traffic is gated and drained, every
// cache is flushed, the new set count is applied, and after a settle window
// the gate is released and a status response is returned.
module vx_cache_cfg_ctrl #(
  parameter int NUM_PORTS     = 4,
  parameter int NUM_CACHES    = 1,
  parameter int PENDING_WIDTH = 8,
  parameter int RESET_SETS    = 64,
  parameter int MIN_SETS      = 16,
  parameter int MAX_SETS      = 2048,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cfg_req_valid_i,
  input  logic [11:0]           cfg_req_sets_i,
  output logic                  cfg_req_ready_o,
  output logic                  cfg_rsp_valid_o,
  output logic                  cfg_rsp_error_o,
  input  logic                  cfg_rsp_ready_i,
  input  logic [NUM_PORTS-1:0]  core_req_fire_i,
  input  logic [NUM_PORTS-1:0]  core_rsp_fire_i,
  output logic                  core_req_gate_o,
  output logic [NUM_CACHES-1:0] flush_valid_o,
  input  logic [NUM_CACHES-1:0] flush_ready_i,
  input  logic [NUM_CACHES-1:0] flush_done_i,
  output logic [11:0]           unified_cache_sets_o,
  output logic                  busy_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_FLUSH  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  localparam logic [11:0] MIN_L   = 12'(MIN_SETS);
  localparam logic [11:0] MAX_L   = 12'(MAX_SETS);
  localparam logic [11:0] RESET_L = 12'(RESET_SETS);

  // Settle counter holds SETTLE_CYCLES-1 down to 0; keep at least one bit.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  // Extended width so add/subtract of per-cycle fire counts never wraps.
  localparam int EW = PENDING_WIDTH + 9;

  function automatic logic [7:0] popcount(input logic [NUM_PORTS-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < NUM_PORTS; i++) c = c + {7'b0, v[i]};
    return c;
  endfunction

  logic [2:0]               state_q, state_d;
  logic [PENDING_WIDTH-1:0] pending_q, pending_d;
  logic [11:0]              sets_q, sets_d;
  logic [11:0]              reqSets_q, reqSets_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic [NUM_CACHES-1:0]    flushValid_q, flushValid_d;
  logic [NUM_CACHES-1:0]    doneMask_q, doneMask_d;
  logic                     reqReady_q, reqReady_d;
  logic                     rspValid_q, rspValid_d;
  logic                     rspError_q, rspError_d;
  logic                     gate_q, gate_d;
  logic                     busy_q, busy_d;

  logic [7:0]    reqCnt, rspCnt;
  logic [EW-1:0] pendPlus, pendDiff, rspExt, pendMax;
  logic          pendUnderflow, pendOverflow;
  logic          reqIsPow2, reqLegal;

  // Track outstanding core requests in every state, saturating at both ends.
  always_comb begin
    reqCnt        = popcount(core_req_fire_i);
    rspCnt        = popcount(core_rsp_fire_i);
    pendMax       = EW'({PENDING_WIDTH{1'b1}});
    pendPlus      = EW'(pending_q) + EW'(reqCnt);
    rspExt        = EW'(rspCnt);
    pendUnderflow = pendPlus < rspExt;
    pendDiff      = pendUnderflow ? '0 : (pendPlus - rspExt);
    pendOverflow  = pendDiff > pendMax;
    if (pendUnderflow) begin
      pending_d = '0;
    end else if (pendOverflow) begin
      pending_d = '1;
    end else begin
      pending_d = pendDiff[PENDING_WIDTH-1:0];
    end
  end

  // Legal set counts are powers of two inside [MIN_SETS, MAX_SETS].
  always_comb begin
    reqIsPow2 = (cfg_req_sets_i != 12'd0) &&
                ((cfg_req_sets_i & (cfg_req_sets_i - 12'd1)) == 12'd0);
    reqLegal  = reqIsPow2 && (cfg_req_sets_i >= MIN_L) && (cfg_req_sets_i <= MAX_L);
  end

  // Sequencer next-state; every output is computed here and registered below.
  always_comb begin
    state_d      = state_q;
    sets_d       = sets_q;
    reqSets_d    = reqSets_q;
    settle_d     = settle_q;
    flushValid_d = flushValid_q;
    doneMask_d   = doneMask_q;
    reqReady_d   = reqReady_q;
    rspValid_d   = rspValid_q;
    rspError_d   = rspError_q;
    gate_d       = gate_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_req_valid_i && reqReady_q) begin
          reqSets_d  = cfg_req_sets_i;
          reqReady_d = 1'b0;
          busy_d     = 1'b1;
          if (!reqLegal) begin
            state_d    = ST_RESP;
            rspValid_d = 1'b1;
            rspError_d = 1'b1;
          end else if (cfg_req_sets_i == sets_q) begin
            state_d    = ST_RESP;
            rspValid_d = 1'b1;
            rspError_d = 1'b0;
          end else begin
            state_d = ST_DRAIN;
            gate_d  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if ((pending_q == '0) && (reqCnt == 8'd0)) begin
          state_d      = ST_FLUSH;
          flushValid_d = '1;
          doneMask_d   = '0;
        end
      end
      ST_FLUSH: begin
        flushValid_d = flushValid_q & ~flush_ready_i;
        doneMask_d   = doneMask_q | flush_done_i;
        if (&doneMask_d) begin
          state_d      = ST_SETTLE;
          sets_d       = reqSets_q;
          settle_d     = SETTLE_LOAD;
          flushValid_d = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d    = ST_RESP;
          gate_d     = 1'b0;
          rspValid_d = 1'b1;
          rspError_d = 1'b0;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_RESP: begin
        if (cfg_rsp_ready_i) begin
          state_d    = ST_IDLE;
          rspValid_d = 1'b0;
          rspError_d = 1'b0;
          reqReady_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        flushValid_d = '0;
        reqReady_d   = 1'b1;
        rspValid_d   = 1'b0;
        rspError_d   = 1'b0;
        gate_d       = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any sequence without a response.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      sets_q       <= RESET_L;
      reqSets_q    <= RESET_L;
      settle_q     <= '0;
      flushValid_q <= '0;
      doneMask_q   <= '0;
      reqReady_q   <= 1'b1;
      rspValid_q   <= 1'b0;
      rspError_q   <= 1'b0;
      gate_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      sets_q       <= sets_d;
      reqSets_q    <= reqSets_d;
      settle_q     <= settle_d;
      flushValid_q <= flushValid_d;
      doneMask_q   <= doneMask_d;
      reqReady_q   <= reqReady_d;
      rspValid_q   <= rspValid_d;
      rspError_q   <= rspError_d;
      gate_q       <= gate_d;
      busy_q       <= busy_d;
    end
  end

  // A response without a request, or more in flight than the counter holds, is a cluster bug.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pendingNoUnderflow: assert (!pendUnderflow);
      pendingNoOverflow: assert (!pendOverflow);
    end
  end

  assign cfg_req_ready_o      = reqReady_q;
  assign cfg_rsp_valid_o      = rspValid_q;
  assign cfg_rsp_error_o      = rspError_q;
  assign core_req_gate_o      = gate_q;
  assign flush_valid_o        = flushValid_q;
  assign unified_cache_sets_o = sets_q;
  assign busy_o               = busy_q;

endmodule
